// File: rtl/piso8_transmitter_if.sv
// Parallel-in / serial-out handshake bundle for piso8_transmitter.
// master = word producer / serial consumer, slave = transmitter.
interface piso8_transmitter_if;
    logic [7:0] pi;
    logic       piValid;
    logic       piReady;
    logic       serOut;
    logic       serValid;
    logic       done;

    modport master (
        output pi,
        output piValid,
        input  piReady,
        input  serOut,
        input  serValid,
        input  done
    );

    modport slave (
        input  pi,
        input  piValid,
        output piReady,
        output serOut,
        output serValid,
        output done
    );
endinterface

// File: rtl/piso8_transmitter.sv
// 8-bit LSB-first parallel-to-serial transmitter with clock enable and done pulse.
// Define PISO8_PARITY_EN to append an even-parity ninth bit (state PAR).
//
// state   | meaning
// --------+---------------------------------------------------------
// S_IDLE  | waiting for piValid; serOut=IDLE_LEVEL, piReady=1
// S_SHIFT | driving data bits 0..7 (r_cnt = index of bit on serOut)
// S_PAR   | driving parity bit (PISO8_PARITY_EN builds only)
module piso8_transmitter #(
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             en,
    piso8_transmitter_if.slave bus
);

`ifdef PISO8_PARITY_EN
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PAR} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_SHIFT} state_t;
`endif

    state_t     r_state;
    state_t     w_state_nxt;
    logic [2:0] r_cnt;
    logic [7:0] r_sh;
    logic       r_ser;
    logic       r_valid;
    logic       r_done;
    logic       w_last;
    logic       w_ser_nxt;
    logic       w_valid_nxt;
    logic       w_done_nxt;

    assign w_last = (r_cnt == 3'd7);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state <= S_IDLE;
        end else if (en) begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.piValid) begin
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_last) begin
`ifdef PISO8_PARITY_EN
                    w_state_nxt = S_PAR;
`else
                    w_state_nxt = S_IDLE;
`endif
                end
            end
`ifdef PISO8_PARITY_EN
            S_PAR: begin
                w_state_nxt = S_IDLE;
            end
`endif
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // The word rotates rather than shifts: after 8 steps it is intact again,
    // so its XOR is still the parity of the captured word.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_cnt <= 3'd0;
            r_sh  <= 8'h00;
        end else if (en) begin
            if (r_state == S_IDLE) begin
                if (bus.piValid) begin
                    r_sh  <= bus.pi;
                    r_cnt <= 3'd0;
                end
            end else if (r_state == S_SHIFT) begin
                r_sh  <= {r_sh[0], r_sh[7:1]};
                r_cnt <= r_cnt + 3'd1;
            end
        end
    end

    always_comb begin
        w_ser_nxt   = IDLE_LEVEL;
        w_valid_nxt = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.piValid) begin
                    w_ser_nxt   = bus.pi[0];
                    w_valid_nxt = 1'b1;
                end
            end
            S_SHIFT: begin
                if (!w_last) begin
                    w_ser_nxt   = r_sh[1];
                    w_valid_nxt = 1'b1;
                end else begin
`ifdef PISO8_PARITY_EN
                    w_ser_nxt   = ^r_sh;
                    w_valid_nxt = 1'b1;
`else
                    w_done_nxt  = 1'b1;
`endif
                end
            end
`ifdef PISO8_PARITY_EN
            S_PAR: begin
                w_done_nxt = 1'b1;
            end
`endif
            default: begin
                w_done_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_ser   <= IDLE_LEVEL;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else if (en) begin
            r_ser   <= w_ser_nxt;
            r_valid <= w_valid_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign bus.serOut   = r_ser;
    assign bus.serValid = r_valid;
    assign bus.done     = r_done;
    assign bus.piReady  = (r_state == S_IDLE);

endmodule

// File: tb/tb_piso8_transmitter.sv
// Randomized + directed bench for piso8_transmitter against a queue-based frame model.
// Honours PISO8_PARITY_EN the same way as the design.
module tb_piso8_transmitter;

    localparam logic IDLE_LV = 1'b1;
`ifdef PISO8_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif

    logic clk  = 1'b0;
    logic rstN = 1'b0;
    logic en   = 1'b0;

    piso8_transmitter_if bus();

    piso8_transmitter #(.IDLE_LEVEL(IDLE_LV)) dut (
        .clk  (clk),
        .rstN (rstN),
        .en   (en),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: frame = queue of bits still to appear on serOut; front is the bit shown now.
    bit         m_q[$];
    logic       m_done = 1'b0;
    logic [7:0] m_last = 8'h00;

    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            m_q.delete();
            m_done = 1'b0;
        end else if (en) begin
            if (m_q.size() != 0) begin
                void'(m_q.pop_front());
                m_done = (m_q.size() == 0);
            end else begin
                m_done = 1'b0;
                if (bus.piValid) begin
                    for (int i = 0; i < 8; i++) m_q.push_back(bus.pi[i]);
                    if (NB == 9) m_q.push_back(^bus.pi);
                    m_last = bus.pi;
                end
            end
        end
    end

    // Serial-in chain sharing the enable: after a full frame po[7:0] holds the word.
    logic [NB-1:0] po;
    always @(posedge clk or negedge rstN) begin
        if (!rstN) po <= '0;
        else if (en) po <= {bus.serOut, po[NB-1:1]};
    end

    always @(negedge clk) begin
        chk("serOut",   bus.serOut,   (m_q.size() != 0) ? m_q[0] : IDLE_LV);
        chk("serValid", bus.serValid, m_q.size() != 0);
        chk("piReady",  bus.piReady,  m_q.size() == 0);
        chk("done",     bus.done,     m_done);
        if (rstN && bus.done) chk("chain", po[7:0], m_last);
    end

    task automatic cyc(input logic e, input logic v, input logic [7:0] d);
        @(negedge clk);
        en = e;
        bus.piValid = v;
        bus.pi = d;
    endtask

    task automatic wait_done(input bit drop, output int n);
        n = 0;
        forever begin
            @(negedge clk);
            if (drop) bus.piValid = 1'b0;
            n++;
            if (bus.done) break;
            if (n > 40) begin
                n_vec++;
                n_err++;
                $display("FAIL wait_done: no done after %0d cycles at %0t", n, $time);
                break;
            end
        end
    endtask

    int n;

    initial begin
        bus.piValid = 1'b0;
        bus.pi = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_piReady",  bus.piReady,  1'b1);
        chk("rst_serValid", bus.serValid, 1'b0);
        chk("rst_done",     bus.done,     1'b0);
        chk("rst_serOut",   bus.serOut,   IDLE_LV);
        @(negedge clk);
        rstN = 1'b1;

        // single frame A5
        cyc(1'b1, 1'b1, 8'hA5);
        wait_done(1'b1, n);
        chk("a5_period", n, NB + 1);
        chk("a5_po", po[7:0], 8'hA5);

        // busy ignore: FF offered throughout the 3C frame
        cyc(1'b1, 1'b1, 8'h3C);
        cyc(1'b1, 1'b1, 8'hFF);
        wait_done(1'b0, n);
        chk("3c_done_at", n, NB);
        chk("3c_po", po[7:0], 8'h3C);
        chk("3c_ready_at_done", bus.piReady, 1'b1);
        wait_done(1'b1, n);
        chk("ff_period", n, NB + 1);
        chk("ff_po", po[7:0], 8'hFF);

        // enable stall after the 4th bit of 81
        cyc(1'b1, 1'b1, 8'h81);
        @(negedge clk);
        bus.piValid = 1'b0;
        repeat (3) @(negedge clk);
        en = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("81_stall_ser", bus.serOut, 1'b0);
            chk("81_stall_valid", bus.serValid, 1'b1);
        end
        en = 1'b1;
        wait_done(1'b1, n);
        chk("81_resume", n, NB - 3);
        chk("81_po", po[7:0], 8'h81);

`ifdef PISO8_PARITY_EN
        cyc(1'b1, 1'b1, 8'h07);
        wait_done(1'b1, n);
        chk("par07", po[8], 1'b1);
        chk("par07_po", po[7:0], 8'h07);
        cyc(1'b1, 1'b1, 8'h03);
        wait_done(1'b1, n);
        chk("par03", po[8], 1'b0);
        chk("par03_po", po[7:0], 8'h03);
`endif

        // reset during the 3rd bit
        cyc(1'b1, 1'b1, 8'h5A);
        @(negedge clk);
        bus.piValid = 1'b0;
        repeat (2) @(negedge clk);
        #2 rstN = 1'b0;
        #1;
        chk("midrst_serValid", bus.serValid, 1'b0);
        chk("midrst_done",     bus.done,     1'b0);
        chk("midrst_piReady",  bus.piReady,  1'b1);
        chk("midrst_serOut",   bus.serOut,   IDLE_LV);
        @(negedge clk);
        rstN = 1'b1;
        bus.piValid = 1'b1;
        bus.pi = 8'hC3;
        wait_done(1'b1, n);
        chk("postrst_period", n, NB + 1);
        chk("postrst_po", po[7:0], 8'hC3);

        // randomized traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            cyc($urandom_range(0, 9) != 0, $urandom_range(0, 2) == 0, 8'($urandom));
            if ($urandom_range(0, 199) == 0) begin
                #2 rstN = 1'b0;
                @(negedge clk);
                rstN = 1'b1;
            end
        end
        cyc(1'b1, 1'b0, 8'h00);
        repeat (12) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
